uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx instance between NUM_REQ byte producers (debug console, status reporter, etc.) using round-robin arbitration.
- Sequences the uart_tx handshake: presents the byte, pulses write_enable, then waits for TC to fall and rise again before granting the next byte.
- Sits between the requesters and uart_tx. Drives uart_tx data_in/write_enable and observes its TC.

Parameters:
- NUM_REQ, 4, number of requesters (1..8)
- PTR_W, 2, width of round-robin pointer; must be ≥ clog2(NUM_REQ), min 1

Ports:
- clk  input  1  system clock (50 MHz)
- reset  input  1  asynchronous, active-low reset
- req  input  NUM_REQ  per-requester byte request; held high until matching ack
- req_data  input  8*NUM_REQ  flattened bytes; requester i uses bits [8*i+7:8*i]
- ack  output  NUM_REQ  one-cycle pulse: requester's byte accepted
- grant  output  NUM_REQ  one-hot owner of the UART; held from issue until byte complete
- busy  output  1  high whenever state != IDLE
- tx_data  output  8  to uart_tx data_in
- tx_write_enable  output  1  to uart_tx write_enable; single-cycle pulse
- tx_TC  input  1  from uart_tx TC

Behaviour:
- Reset (reset==0, async): state=IDLE, ptr=0, ack=0, grant=0, busy=0, tx_data=0, tx_write_enable=0. Takes effect immediately, including mid-byte. uart_tx is reset separately.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH.
- IDLE:
  - If tx_TC==1 and any req, pick the winner w = first set req scanning ptr, ptr+1, …, NUM_REQ-1, 0, … (wrap).
  - Latch tx_data<=req_data[w], grant<=onehot(w), then go to ISSUE.
  - If tx_TC==0, no grant; stay in IDLE.
- ISSUE (exactly 1 cycle):
  - tx_write_enable=1 and ack[w]=1 in this cycle only.
  - Go to WAIT_LOW.
- WAIT_LOW: wait for tx_TC==0 (uart_tx drops TC the cycle after the write_enable edge), then go to WAIT_HIGH.
- WAIT_HIGH: wait for tx_TC==1.
  - Then grant<=0, ptr<=(w+1) mod NUM_REQ (wrap from NUM_REQ-1 to 0), go to IDLE.
- Latency: req seen in IDLE at edge N gives tx_write_enable/ack high during cycle N+1. The next grant is possible no earlier than 1 cycle after TC returns high.
- Requester rules:
  - May deassert req or change req_data on the cycle after ack.
  - req_data must be stable while req is high and not yet acked.
  - A req dropped before grant is simply not served; nothing is latched.
- Boundaries:
  - All req high continuously: grant order 0,1,2,3,0,…
  - Single requester: served back-to-back, one byte per UART frame.
  - req changes while in ISSUE/WAIT_*: ignored until IDLE.
  - NUM_REQ==1: ptr stays 0.
  - tx_data holds its last value between bytes.

Optional Feature:
- Macro: UART_TX_ARB_LOCK_EN.
- Defined:
  - Adds input lock [NUM_REQ].
  - If lock[w]==1 on the WAIT_HIGH→IDLE transition, grant stays on w, ptr is not advanced, and IDLE considers only req[w]. Other requesters wait.
  - Ownership is released when lock[w]==0 in IDLE; normal round-robin then resumes from w+1.
  - Purpose: a multi-byte message is never interleaved with other requesters' bytes.
  - lock on a non-owner is ignored.
- Not defined: no lock port; pure round-robin after every byte.

Test Plan:
- Reset, tx_TC=1, req=4'b0100, byte 8'h41 on slot 2 → one cycle later tx_write_enable=1, ack=4'b0100, tx_data=8'h41, grant=4'b0100. A model uart_tx (9600 baud) shows frame 0x41. grant returns to 0 after TC rises. ptr=3.
- req=4'b1111 held, slot i data = 8'h30+i → UART frames 0x30, 0x31, 0x32, 0x33, 0x30 in order. Exactly one ack per frame.
- ptr=3 (after serving slot 2), req=4'b1001 → slot 3 granted before slot 0 (wrap check).
- tx_TC forced 0 in IDLE, req=4'b0001 → no tx_write_enable, no ack, until tx_TC=1. Grant follows one cycle later.
- Assert reset during WAIT_HIGH mid-frame → grant, busy, ack and tx_write_enable go 0 immediately without a clock edge. After release, ptr=0.
- With UART_TX_ARB_LOCK_EN: slot 1 sends 3 bytes with lock[1]=1 while req[0] is high → frames from slot1, slot1, slot1, then slot0 after lock drops.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte producers.
// Define UART_TX_ARB_LOCK_EN to add per-requester lock (multi-byte ownership).
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]   lock,
`endif
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic [7:0]           tx_data,
  output logic                 tx_write_enable,
  input  logic                 tx_TC
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_WAIT_LOW  = 2'd2;
  localparam logic [1:0] S_WAIT_HIGH = 2'd3;

  logic [1:0]         state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   owner;
  logic [NUM_REQ-1:0] req_eff;
  logic [PTR_W-1:0]   win;
  logic               found;
`ifdef UART_TX_ARB_LOCK_EN
  logic               locked;
`endif

  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_REQ-1:0] r;
    r = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  // While a lock is held only the owner may compete.
  always_comb begin
    req_eff = req;
`ifdef UART_TX_ARB_LOCK_EN
    if (locked) req_eff = req & onehot(owner);
`endif
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_eff[next_idx(ptr, k)]) begin
        found = 1'b1;
        win   = next_idx(ptr, k);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      ptr             <= '0;
      owner           <= '0;
      ack             <= '0;
      grant           <= '0;
      busy            <= 1'b0;
      tx_data         <= '0;
      tx_write_enable <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
      locked          <= 1'b0;
`endif
    end else begin
      ack             <= '0;
      tx_write_enable <= 1'b0;
      case (state)
        S_IDLE: begin
`ifdef UART_TX_ARB_LOCK_EN
          if (locked && !lock[owner]) begin
            locked <= 1'b0;
            grant  <= '0;
            ptr    <= next_idx(owner, 1);
          end else
`endif
          if (tx_TC && found) begin
            tx_data         <= req_data[8*int'(win) +: 8];
            grant           <= onehot(win);
            ack             <= onehot(win);
            owner           <= win;
            tx_write_enable <= 1'b1;
            busy            <= 1'b1;
            state           <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT_LOW;
        S_WAIT_LOW: begin
          if (!tx_TC) state <= S_WAIT_HIGH;
        end
        S_WAIT_HIGH: begin
          if (tx_TC) begin
            state <= S_IDLE;
            busy  <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
            if (lock[owner]) begin
              locked <= 1'b1;
            end else begin
              grant <= '0;
              ptr   <= next_idx(owner, 1);
            end
`else
            grant <= '0;
            ptr   <= next_idx(owner, 1);
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
